// File: rtl/seg7_scan_driver_if.sv
// Upstream-facing bundle of the seven-segment scan driver.
// The lab logic drives values and enables; the driver returns segments, digit selects and frame pulse.
interface seg7_scan_driver_if #(
    parameter int w_digit = 8
);
    logic [w_digit*4-1:0] number;
    logic [w_digit-1:0]   dots;
    logic [w_digit-1:0]   digit_en;
    logic [w_digit-1:0]   raw_en;
    logic [w_digit*8-1:0] raw_seg;
    logic [7:0]           abcdefgh;
    logic [w_digit-1:0]   digit;
    logic                 frame_start;

    modport master (
        output number, dots, digit_en, raw_en, raw_seg,
        input  abcdefgh, digit, frame_start
    );

    modport slave (
        input  number, dots, digit_en, raw_en, raw_seg,
        output abcdefgh, digit, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner: one digit per slot, blanking gap at slot start.
// Inputs are snapshotted once per frame; all outputs are registered and aligned with cnt/idx.
module seg7_scan_driver #(
    parameter int clk_mhz     = 50,
    parameter int w_digit     = 8,
    parameter int digit_hz    = 1000,
    parameter int dead_cycles = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_driver_if.slave    bus
);
    localparam int PERIOD = clk_mhz * 1_000_000 / digit_hz;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int IW     = $clog2(w_digit);

    localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(w_digit - 1);
    localparam logic [CW-1:0] DEAD    = CW'(dead_cycles);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [w_digit*4-1:0] snap_num_q, snap_num_d;
    logic [w_digit-1:0]   snap_dots_q, snap_dots_d;
    logic [w_digit-1:0]   snap_en_q, snap_en_d;
    logic [w_digit-1:0]   snap_raw_en_q, snap_raw_en_d;
    logic [w_digit*8-1:0] snap_raw_q, snap_raw_d;
    logic [7:0]           seg_q, seg_d;
    logic [w_digit-1:0]   digit_q, digit_d;
    logic                 frame_start_q, frame_start_d;

    logic [3:0]           nib;
    logic [7:0]           hex;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 8'hFC;
            4'h1: hex_seg = 8'h60;
            4'h2: hex_seg = 8'hDA;
            4'h3: hex_seg = 8'hF2;
            4'h4: hex_seg = 8'h66;
            4'h5: hex_seg = 8'hB6;
            4'h6: hex_seg = 8'hBE;
            4'h7: hex_seg = 8'hE0;
            4'h8: hex_seg = 8'hFE;
            4'h9: hex_seg = 8'hF6;
            4'hA: hex_seg = 8'hEE;
            4'hB: hex_seg = 8'h3E;
            4'hC: hex_seg = 8'h9C;
            4'hD: hex_seg = 8'h7A;
            4'hE: hex_seg = 8'h9E;
            default: hex_seg = 8'h8E;
        endcase
    endfunction

    // Outputs are computed from the next cnt/idx/snapshot so the registered
    // values line up with the counter state of the same cycle.
    always_comb begin
        cnt_d         = cnt_q + 1'b1;
        idx_d         = idx_q;
        snap_num_d    = snap_num_q;
        snap_dots_d   = snap_dots_q;
        snap_en_d     = snap_en_q;
        snap_raw_en_d = snap_raw_en_q;
        snap_raw_d    = snap_raw_q;
        digit_d       = '0;
        seg_d         = '0;

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        frame_start_d = (cnt_d == '0) && (idx_d == '0);
        if (frame_start_d) begin
            snap_num_d    = bus.number;
            snap_dots_d   = bus.dots;
            snap_en_d     = bus.digit_en;
            snap_raw_en_d = bus.raw_en;
            snap_raw_d    = bus.raw_seg;
        end

        nib = snap_num_d[4*idx_d +: 4];
        hex = hex_seg(nib);

        if ((cnt_d >= DEAD) && snap_en_d[idx_d]) begin
            digit_d = {{(w_digit-1){1'b0}}, 1'b1} << idx_d;
            if (snap_raw_en_d[idx_d]) begin
                seg_d = snap_raw_d[8*idx_d +: 8];
            end else begin
                seg_d = hex | {7'b0, snap_dots_d[idx_d]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= CNT_MAX;
            idx_q         <= IDX_MAX;
            snap_num_q    <= '0;
            snap_dots_q   <= '0;
            snap_en_q     <= '0;
            snap_raw_en_q <= '0;
            snap_raw_q    <= '0;
            seg_q         <= '0;
            digit_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_num_q    <= snap_num_d;
            snap_dots_q   <= snap_dots_d;
            snap_en_q     <= snap_en_d;
            snap_raw_en_q <= snap_raw_en_d;
            snap_raw_q    <= snap_raw_d;
            seg_q         <= seg_d;
            digit_q       <= digit_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.abcdefgh    = seg_q;
    assign bus.digit       = digit_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: 4 digits, 10-cycle slots, 2 blank cycles per slot.
module tb_seg7_scan_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.w_digit(4)) bus();

    seg7_scan_driver #(
        .clk_mhz(1), .w_digit(4), .digit_hz(100000), .dead_cycles(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic       fs;
        logic [3:0] dig;
        logic [7:0] seg;
    } exp_t;

    localparam logic [7:0] HEX_TBL [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    exp_t       exp_q[$];
    exp_t       e_mon;
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         checking = 1'b0;
    logic [3:0] prev_dig = '0;

    task automatic check_out(input string name, input exp_t req);
        exp_t act;
        act = '{bus.frame_start, bus.digit, bus.abcdefgh};
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got fs=%b digit=%b seg=%h, required fs=%b digit=%b seg=%h",
                     name, $time, act.fs, act.dig, act.seg, req.fs, req.dig, req.seg);
        end
    endtask

    task automatic check_bit(input string name, input bit ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s @%0t: digit=%b seg=%h", name, $time, bus.digit, bus.abcdefgh);
        end
    endtask

    // Monitor: pops one expected entry per cycle and checks invariants.
    always @(negedge clk) begin
        if (checking) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow @%0t: got empty queue, required an entry", $time);
            end else begin
                e_mon = exp_q.pop_front();
                check_out("scan", e_mon);
            end
        end
        if (!rst) begin
            check_bit("onehot_or_zero", $countones(bus.digit) <= 1);
            check_bit("seg_zero_when_blank", (bus.digit != 0) || (bus.abcdefgh == 0));
            check_bit("blank_gap", (bus.digit == 0) || (prev_dig == 0) || (bus.digit == prev_dig));
            prev_dig = bus.digit;
        end else begin
            prev_dig = '0;
        end
    end

    // Applies inputs before the next frame's snapshot edge, queues the expected
    // per-cycle outputs for the first ncyc cycles, and advances ncyc cycles.
    task automatic run_frame(input logic [15:0] num, input logic [3:0] dots,
                             input logic [3:0] en, input logic [3:0] raw_en,
                             input logic [31:0] raw,
                             input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3,
                             input int ncyc, input int mid_cyc, input logic [15:0] mid_num);
        logic [7:0] segs [4];
        exp_t e;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        bus.number   = num;
        bus.dots     = dots;
        bus.digit_en = en;
        bus.raw_en   = raw_en;
        bus.raw_seg  = raw;
        for (int c = 1; c <= ncyc; c++) begin
            int slot, pos;
            slot  = (c - 1) / 10;
            pos   = (c - 1) % 10;
            e.fs  = (c == 1);
            e.dig = '0;
            e.seg = '0;
            if (pos >= 2 && en[slot]) begin
                e.dig = 4'(1 << slot);
                e.seg = segs[slot];
            end
            exp_q.push_back(e);
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            if (c == mid_cyc) bus.number = mid_num;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        exp_q.push_back('0);
        checking = 1'b1;
        rst      = 1'b0;
    endtask

    initial begin
        bus.number   = '0;
        bus.dots     = '0;
        bus.digit_en = '0;
        bus.raw_en   = '0;
        bus.raw_seg  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_state", '0);
        release_reset();

        // Startup frame, then a mid-frame number change that must not show up.
        run_frame(16'h1234, 4'h0, 4'hF, 4'h0, 32'h0, 8'h66, 8'hF2, 8'hDA, 8'h60, 40, 0, 16'h0);
        run_frame(16'h1234, 4'h0, 4'hF, 4'h0, 32'h0, 8'h66, 8'hF2, 8'hDA, 8'h60, 40, 15, 16'hABCD);
        run_frame(16'hABCD, 4'h0, 4'hF, 4'h0, 32'h0, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 40, 0, 16'h0);
        // Masking, raw byte with dot ignored, and dot on a hex digit.
        run_frame(16'hABCD, 4'h0, 4'b0101, 4'h0, 32'h0, 8'h7A, 8'h00, 8'h3E, 8'h00, 40, 0, 16'h0);
        run_frame(16'hABCD, 4'b0001, 4'hF, 4'b0001, 32'h0000_0081, 8'h81, 8'h9C, 8'h3E, 8'hEE, 40, 0, 16'h0);
        run_frame(16'hABC8, 4'b0001, 4'hF, 4'h0, 32'h0, 8'hFF, 8'h9C, 8'h3E, 8'hEE, 40, 0, 16'h0);

        // Async reset while digit 2 is lit (cycle 24 of the frame).
        run_frame(16'h1234, 4'h0, 4'hF, 4'h0, 32'h0, 8'h66, 8'hF2, 8'hDA, 8'h60, 24, 0, 16'h0);
        #6;
        check_bit("digit2_lit_before_reset", bus.digit == 4'b0100);
        checking = 1'b0;
        rst      = 1'b1;
        #1;
        check_out("async_reset_immediate", '0);
        bus.number = 16'h5678;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_held", '0);
        release_reset();
        run_frame(16'h5678, 4'h0, 4'hF, 4'h0, 32'h0, 8'hFE, 8'hE0, 8'hBE, 8'hB6, 40, 0, 16'h0);

        // Decode sweep of digit 0; other digits stay 0.
        for (int k = 0; k < 16; k++) begin
            run_frame({12'h000, 4'(k)}, 4'h0, 4'hF, 4'h0, 32'h0,
                      HEX_TBL[k], 8'hFC, 8'hFC, 8'hFC, 40, 0, 16'h0);
        end

        @(negedge clk);
        #1;
        check_bit("scoreboard_drained", exp_q.size() == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end
endmodule
